// File: rtl/line_buffer_window_gen.sv
// Raster pixel stream to 3x3 sliding windows (stride 1, no padding) for the conv core.
// Two line buffers hold rows r-1 and r-2; the window register array doubles as the output.
module line_buffer_window_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
  parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pix_in,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic [0:8][DATA_WIDTH-1:0]  win_out,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [ROW_W-1:0]            win_row,
  output logic [COL_W-1:0]            win_col,
  output logic                        frame_done
);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                state;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] tap_a;
  logic [DATA_WIDTH-1:0] tap_b;
  logic                  accept;
  logic                  last_col;
  logic                  last_row;
  logic                  emit;

  // A new pixel may enter only when the current window slot is free or draining this edge.
  assign pix_ready = rst & (~win_valid | win_ready);
  assign accept    = pix_valid & pix_ready;
  assign last_col  = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row  = (row == ROW_W'(IMG_HEIGHT - 1));
  assign emit      = accept & (state == STREAM) & (col >= COL_W'(2));
  assign tap_a     = lb1[col];
  assign tap_b     = lb0[col];

  // Line buffers: column-wise shift of rows r-1 -> r-2 and current -> r-1; contents not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= tap_b;
      lb0[col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        win_out <= {win_out[1], win_out[2], tap_a,
                    win_out[4], win_out[5], tap_b,
                    win_out[7], win_out[8], pix_in};
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        case (state)
          FILL:   if (last_col && row == ROW_W'(1)) state <= STREAM;
          STREAM: if (last_col && last_row)         state <= FILL;
        endcase
      end

      // Same-edge emit wins over handshake clear to keep one window per cycle.
      if (emit) begin
        win_valid  <= 1'b1;
        win_row    <= row - ROW_W'(2);
        win_col    <= col - COL_W'(2);
        frame_done <= last_col & last_row;
      end else if (win_ready) begin
        win_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_window_gen.sv
// Directed bench: 4x4 instance for hand-computed windows, 32x32 instance for random frames.
module tb_line_buffer_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:8][7:0] win;
    logic [7:0]      row;
    logic [7:0]      col;
    logic            fd;
  } exp_t;

  localparam logic [0:8][7:0] FIRST_WIN = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
  localparam logic [0:8][7:0] LAST_WIN  = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- 4x4 instance ----------------
  logic            s_rst = 1'b0;
  logic [7:0]      s_pix_in = '0;
  logic            s_pix_valid = 1'b0;
  logic            s_pix_ready;
  logic [0:8][7:0] s_win_out;
  logic            s_win_valid;
  logic            s_win_ready = 1'b1;
  logic [1:0]      s_win_row;
  logic [1:0]      s_win_col;
  logic            s_frame_done;

  line_buffer_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
    .clk(clk), .rst(s_rst), .pix_in(s_pix_in), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .win_out(s_win_out), .win_valid(s_win_valid), .win_ready(s_win_ready),
    .win_row(s_win_row), .win_col(s_win_col), .frame_done(s_frame_done)
  );

  // ---------------- 32x32 instance ----------------
  logic            b_rst = 1'b0;
  logic [7:0]      b_pix_in = '0;
  logic            b_pix_valid = 1'b0;
  logic            b_pix_ready;
  logic [0:8][7:0] b_win_out;
  logic            b_win_valid;
  logic            b_win_ready = 1'b1;
  logic [4:0]      b_win_row;
  logic [4:0]      b_win_col;
  logic            b_frame_done;

  line_buffer_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(32), .IMG_HEIGHT(32)) u_big (
    .clk(clk), .rst(b_rst), .pix_in(b_pix_in), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
    .win_out(b_win_out), .win_valid(b_win_valid), .win_ready(b_win_ready),
    .win_row(b_win_row), .win_col(b_win_col), .frame_done(b_frame_done)
  );

  exp_t       s_q[$];
  exp_t       b_q[$];
  logic [7:0] img [2][32][32];
  int         b_fd_seen  = 0;
  int         b_win_seen = 0;

  // Scoreboards: a handshake happens at the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (s_win_valid && s_win_ready) begin
      if (s_q.size() == 0) check_eq("s_extra_window", 96'(1), 96'(0));
      else begin
        e = s_q.pop_front();
        check_eq($sformatf("s_win_%0d_%0d", e.row, e.col), 96'(s_win_out), 96'(e.win));
        check_eq("s_win_row", 96'(s_win_row), 96'(e.row));
        check_eq("s_win_col", 96'(s_win_col), 96'(e.col));
        check_eq("s_frame_done", 96'(s_frame_done), 96'(e.fd));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_win_valid && b_win_ready) begin
      b_win_seen++;
      if (b_frame_done) b_fd_seen++;
      if (b_q.size() == 0) check_eq("b_extra_window", 96'(1), 96'(0));
      else begin
        e = b_q.pop_front();
        check_eq($sformatf("b_win_%0d_%0d", e.row, e.col), 96'(b_win_out), 96'(e.win));
        check_eq("b_win_row", 96'(b_win_row), 96'(e.row));
        check_eq("b_win_col", 96'(b_win_col), 96'(e.col));
        check_eq("b_frame_done", 96'(b_frame_done), 96'(e.fd));
      end
    end
  end

  function automatic void push_small();
    exp_t e;
    for (int wr = 0; wr < 2; wr++)
      for (int wc = 0; wc < 2; wc++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i*3+j] = 8'((wr + i) * 4 + (wc + j) + 1);
        e.row = 8'(wr);
        e.col = 8'(wc);
        e.fd  = (wr == 1 && wc == 1);
        s_q.push_back(e);
      end
  endfunction

  task automatic check_small_reset(input string tag);
    check_eq({tag, "_pix_ready"}, 96'(s_pix_ready), 96'(0));
    check_eq({tag, "_win_valid"}, 96'(s_win_valid), 96'(0));
    check_eq({tag, "_frame_done"}, 96'(s_frame_done), 96'(0));
    check_eq({tag, "_win_out"}, 96'(s_win_out), 96'(0));
    check_eq({tag, "_win_row"}, 96'(s_win_row), 96'(0));
    check_eq({tag, "_win_col"}, 96'(s_win_col), 96'(0));
  endtask

  // Feed n_px pixels of the 4x4 ramp image; gap = percent bubble chance; stall = 5-cycle hold on first window.
  task automatic run_small(input int n_px, input int gap, input bit stall);
    int  idx = 0;
    int  guard = 0;
    bit  acc;
    bit  stalled = 1'b0;
    while (idx < n_px && guard < 1000) begin
      if (stall && !stalled && s_win_valid) begin
        stalled = 1'b1;
        s_win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check_eq("bp_pix_ready", 96'(s_pix_ready), 96'(0));
          check_eq("bp_win_valid", 96'(s_win_valid), 96'(1));
          check_eq("bp_win_out", 96'(s_win_out), 96'(FIRST_WIN));
        end
        s_win_ready = 1'b1;
      end
      s_pix_valid = ($urandom_range(0, 99) >= gap);
      s_pix_in    = 8'(idx + 1);
      @(negedge clk);
      acc = s_pix_valid && s_pix_ready;
      @(posedge clk); #1;
      if (acc) begin
        check_eq($sformatf("latency_px%0d", idx), 96'(s_win_valid),
                 96'((idx / 4 >= 2) && (idx % 4 >= 2)));
        if (idx == 10) check_eq("first_window", 96'(s_win_out), 96'(FIRST_WIN));
        if (idx == 15) begin
          check_eq("last_window", 96'(s_win_out), 96'(LAST_WIN));
          check_eq("last_frame_done", 96'(s_frame_done), 96'(1));
        end
        idx++;
      end
      guard++;
    end
    if (guard >= 1000) check_eq("s_timeout_pixels", 96'(idx), 96'(n_px));
    s_pix_valid = 1'b0;
    if (n_px == 16) begin
      @(posedge clk); #1;
      check_eq("post_frame_done", 96'(s_frame_done), 96'(0));
      check_eq("post_win_valid", 96'(s_win_valid), 96'(0));
      check_eq("s_windows_left", 96'(s_q.size()), 96'(0));
    end
  endtask

  initial begin
    int  idx;
    int  guard;
    bit  acc;
    exp_t e;

    // Reset state of the small instance.
    s_pix_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_pix_ready", 96'(s_pix_ready), 96'(0));
    repeat (2) @(posedge clk);
    #1;
    check_small_reset("rst");
    s_rst = 1'b1;
    s_pix_valid = 1'b0;

    // Gap-free frame, then backpressure, then 50% bubbles; same expected sequence each time.
    push_small(); run_small(16, 0, 1'b0);
    push_small(); run_small(16, 0, 1'b1);
    push_small(); run_small(16, 50, 1'b0);

    // Abort a frame after 9 pixels, then restart from (0,0).
    run_small(9, 0, 1'b0);
    s_rst = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_in = 8'hAA;
    @(posedge clk); #1;
    check_small_reset("midrst");
    s_rst = 1'b1;
    s_pix_valid = 1'b0;
    push_small(); run_small(16, 0, 1'b0);

    // Two back-to-back 32x32 random frames with random valid/ready.
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          img[f][r][c] = 8'($urandom_range(0, 255));
    for (int f = 0; f < 2; f++)
      for (int wr = 0; wr < 30; wr++)
        for (int wc = 0; wc < 30; wc++) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.win[i*3+j] = img[f][wr+i][wc+j];
          e.row = 8'(wr);
          e.col = 8'(wc);
          e.fd  = (wr == 29 && wc == 29);
          b_q.push_back(e);
        end
    idx = 0;
    guard = 0;
    while (idx < 2048 && guard < 30000) begin
      b_win_ready = ($urandom_range(0, 3) != 0);
      b_pix_valid = ($urandom_range(0, 3) != 0);
      b_pix_in    = img[idx / 1024][(idx / 32) % 32][idx % 32];
      @(negedge clk);
      acc = b_pix_valid && b_pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    if (guard >= 30000) check_eq("b_timeout_pixels", 96'(idx), 96'(2048));
    b_pix_valid = 1'b0;
    b_win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("b_windows_left", 96'(b_q.size()), 96'(0));
    check_eq("b_window_count", 96'(b_win_seen), 96'(1800));
    check_eq("b_frame_done_pulses", 96'(b_fd_seen), 96'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_window_gen.md
Name: line_buffer_window_gen

Overview:
- Upstream neighbour of the 3x3 convolution core: turns a raster-order pixel stream into 3x3 sliding windows of DATA_WIDTH-bit pixels, stride 1, no padding.
- Two on-chip line buffers hold the previous two image rows; a 3x3 register array holds the current window.
- The window output port is shaped to connect directly to the conv core's 9-element input_window port, with valid/ready flow control on both sides.

Parameters:
- DATA_WIDTH, 8, pixel width in bits (raw bits; signedness is interpreted downstream).
- IMG_WIDTH, 32, pixels per row; legal range >= 3.
- IMG_HEIGHT, 32, rows per frame; legal range >= 3.
- COL_W, $clog2(IMG_WIDTH), width of column counter and coordinate outputs.
- ROW_W, $clog2(IMG_HEIGHT), width of row counter and coordinate outputs.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 sampled at a rising clk edge resets the block.
- pix_in  in  DATA_WIDTH  input pixel, raster order, row 0 col 0 first.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- win_out  out  9 x DATA_WIDTH  window [0:8], row-major; [0]=top-left (row r-2, col c-2), [8]=bottom-right (row r, col c).
- win_valid  out  1  win_out holds a valid window.
- win_ready  in  1  downstream accepts the window this cycle.
- win_row  out  ROW_W  top-left row of the current window (r-2).
- win_col  out  COL_W  top-left column of the current window (c-2).
- frame_done  out  1  one-cycle pulse, asserted with the frame's last window.

Behaviour:
- Reset (rst=0 at clk edge):
  - Outputs: pix_ready=0, win_valid=0, frame_done=0, win_out=0, win_row=0, win_col=0.
  - Internal: col=0, row=0, window registers cleared, state=FILL.
  - Line buffer RAM contents are not cleared; they are don't-care until overwritten.
  - Reset mid-frame aborts the frame. The next accepted pixel is treated as (0,0).
- pix_ready:
  - 0 during the reset cycle.
  - Otherwise equals (!win_valid || win_ready); combinational from win_valid and win_ready.
- Accept: a pixel is accepted when pix_valid && pix_ready at a clk edge. Only accepted pixels advance any state.
- On accepting pixel P at (row, col):
  - Read A = lb1[col] (row-2) and B = lb0[col] (row-1).
  - Write lb1[col] <= B and lb0[col] <= P.
  - Shift the window left by one column; the new right column, top to bottom, is {A, B, P}.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both col and row wrap to 0.
- States:
  - FILL: row < 2. No windows are emitted.
  - STREAM: row >= 2.
  - FILL -> STREAM on accepting the last pixel of row 1.
  - STREAM -> FILL on accepting the last pixel of the frame.
- Window emission:
  - Condition: accepted pixel has row >= 2 and col >= 2.
  - Next cycle: win_valid=1 and win_out holds the new window.
  - win_row = row-2, win_col = col-2, registered with win_out.
  - Latency is exactly 1 cycle from acceptance to win_valid.
- Hold rule: while win_valid && !win_ready, win_out, win_row, win_col and win_valid hold stable. No pixel can be accepted because pix_ready=0.
- Clearing win_valid:
  - win_valid drops after the handshake (win_valid && win_ready) unless the same edge accepts a pixel that produces a new window.
  - A same-edge accept keeps full throughput: 1 window per cycle in STREAM, interior columns.
- Row boundaries:
  - Accepting col 0 or col 1 of any row produces no window; win_valid clears once the pending window handshakes.
  - Windows never straddle rows.
- frame_done: asserted for the same cycle(s) as the window at (IMG_HEIGHT-3, IMG_WIDTH-3). It holds with the window under backpressure and clears on handshake.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Back-to-back frames need no idle cycle.

Test Plan:
- Basic window, IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*4+col+1, pix_valid=1, win_ready=1 -> first win_valid 1 cycle after accepting value 11, win_out={1,2,3,5,6,7,9,10,11}, win_row=0, win_col=0.
- Full frame, same config -> exactly 4 windows in order (0,0),(0,1),(1,0),(1,1); last window = {6,7,8,10,11,12,14,15,16} with frame_done=1 for 1 cycle.
- Backpressure: hold win_ready=0 for 5 cycles on the first window -> pix_ready=0, win_out and win_valid stable 5 cycles; on release no window is lost or duplicated.
- Bubbles: random pix_valid gaps (50%) -> window sequence and values identical to the gap-free run.
- Mid-frame reset: assert rst=0 after 9 pixels accepted, then restart the frame -> all outputs 0 in the reset cycle; first window again = {1,2,3,5,6,7,9,10,11}.
- Back-to-back frames at IMG_WIDTH=32, IMG_HEIGHT=32 with random data and random win_ready -> 900 windows per frame, matching a software 3x3 sliding reference; frame_done pulses once per frame.
